// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the digit-serial adder/subtractor.
//   state_t   : controller states (IDLE, RUN, DONE)
//   cnt_width : width of the digit counter, $clog2(WIDTH/DIGIT) but never 0
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-digit operation (DIGIT == WIDTH) still needs a 1-bit counter.
    function automatic int cnt_width(input int width, input int digit);
        int w;
        w = $clog2(width / digit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit ripple of full-adder cells.
//   x, y     : DIGIT-bit addend digits
//   cin      : carry into bit 0
//   s        : DIGIT-bit sum digit
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (gives signed overflow on the last digit)
// -----------------------------------------------------------------------------
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
            assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
        end
    endgenerate

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Multi-cycle adder/subtractor: WIDTH-bit operands processed LSB-first,
// DIGIT bits per clock, through a registered carry.
//   clk, rst       : clock, synchronous active-high reset
//   start, ready   : request / can-accept (accepted when both high at an edge)
//   sub            : 0 = a+b, 1 = a-b (sampled with start)
//   a, b           : operands (sampled with start)
//   busy           : computation in progress
//   done           : one-cycle pulse, result registers just updated
//   sum, cout, ovf : result, carry out of MSB, two's-complement overflow
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_adder: WIDTH/DIGIT combination not supported");
        end
    endgenerate

    localparam int             N    = WIDTH / DIGIT;
    localparam int             CW   = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg, psum_reg, sum_reg;
    logic              carry_reg, cout_reg, ovf_reg;
    logic [CW-1:0]     cnt_reg;

    logic              accept, running, last_digit;
    logic [DIGIT-1:0]  dig_s;
    logic              dig_cout, dig_c_msb;
    logic [WIDTH-1:0]  psum_shifted;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x        (a_reg[DIGIT-1:0]),
        .y        (b_reg[DIGIT-1:0]),
        .cin      (carry_reg),
        .s        (dig_s),
        .cout     (dig_cout),
        .c_msb_in (dig_c_msb)
    );

    assign accept     = start && ready;
    assign running    = (state_reg == RUN);
    assign last_digit = running && (cnt_reg == LAST);

    // New digit enters at the top; after N steps the LSB digit reaches bit 0.
    assign psum_shifted = (psum_reg >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_digit) state_next = DONE;
            end
            DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            psum_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            // Subtraction as a + ~b + 1: the +1 rides in on the initial carry.
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= sub;
            cnt_reg   <= '0;
            psum_reg  <= '0;
        end else if (running) begin
            a_reg     <= a_reg >> DIGIT;
            b_reg     <= b_reg >> DIGIT;
            carry_reg <= dig_cout;
            cnt_reg   <= cnt_reg + CW'(1);
            psum_reg  <= psum_shifted;
            if (last_digit) begin
                sum_reg  <= psum_shifted;
                cout_reg <= dig_cout;
                ovf_reg  <= dig_c_msb ^ dig_cout;
            end
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Four instances (WIDTH=8, DIGIT = 1, 2, 4, 8) against an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start_v;
    logic        sub;
    logic [7:0]  a, b;
    logic [3:0]  ready_v, busy_v, done_v, cout_v, ovf_v;
    logic [7:0]  sum_v [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dut
            serial_adder #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
                .clk   (clk),
                .rst   (rst),
                .start (start_v[gi]),
                .sub   (sub),
                .a     (a),
                .b     (b),
                .ready (ready_v[gi]),
                .busy  (busy_v[gi]),
                .done  (done_v[gi]),
                .sum   (sum_v[gi]),
                .cout  (cout_v[gi]),
                .ovf   (ovf_v[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned / signed integer arithmetic. Returns {cout, ovf, sum}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        int         sx, sy, r;
        logic [7:0] res;
        logic       c, o;
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        r   = s ? (sx - sy) : (sx + sy);
        o   = (r > 127) || (r < -128);
        res = s ? (x - y) : (x + y);
        c   = s ? (x >= y) : ((int'(x) + int'(y)) > 255);
        return {c, o, res};
    endfunction

    // Invariants checked every cycle.
    logic [3:0] done_prev = '0;
    always @(negedge clk) begin
        check("ready_busy_excl", ready_v & busy_v, 0);
        if (done_prev != 0) check("done_consecutive", done_prev & done_v, 0);
        done_prev = done_v;
    end

    // Launch the same operation on all four instances; check result and timing.
    task automatic run_all(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [9:0] exp;
        int lat [4];
        int busy_n [4];
        int done_n [4];
        exp = model(x, y, s);
        for (int k = 0; k < 4; k++) begin
            lat[k] = -1; busy_n[k] = 0; done_n[k] = 0;
        end
        a = x; b = y; sub = s; start_v = 4'hF;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start_v = '0;
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            for (int k = 0; k < 4; k++) begin
                if (busy_v[k]) busy_n[k]++;
                if (done_v[k]) begin
                    done_n[k]++;
                    if (lat[k] < 0) begin
                        lat[k] = cyc - 1;
                        check($sformatf("sum d%0d %h%s%h", 1 << k, x, s ? "-" : "+", y), sum_v[k], exp[7:0]);
                        check($sformatf("cout d%0d %h%s%h", 1 << k, x, s ? "-" : "+", y), cout_v[k], exp[9]);
                        check($sformatf("ovf d%0d %h%s%h", 1 << k, x, s ? "-" : "+", y), ovf_v[k], exp[8]);
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("latency d%0d", 1 << k), lat[k], 8 >> k);
            check($sformatf("busy_cycles d%0d", 1 << k), busy_n[k], 8 >> k);
            check($sformatf("done_pulses d%0d", 1 << k), done_n[k], 1);
        end
    endtask

    initial begin
        logic [9:0] e1, e2;
        int         cyc, gap, unstable, done_seen;

        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] e1, e2;
        int         cyc, gap, unstable, done_seen;

        rst = 1'b1; start_v = '0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset ready d%0d", 1 << k), ready_v[k], 1);
            check($sformatf("reset busy d%0d", 1 << k), busy_v[k], 0);
            check($sformatf("reset done d%0d", 1 << k), done_v[k], 0);
            check($sformatf("reset sum d%0d", 1 << k), sum_v[k], 0);
            check($sformatf("reset cout d%0d", 1 << k), cout_v[k], 0);
            check($sformatf("reset ovf d%0d", 1 << k), ovf_v[k], 0);
        end

        // Directed cases
        run_all(8'h00, 8'h00, 1'b0);
        run_all(8'hFF, 8'h01, 1'b0);
        run_all(8'h7F, 8'h01, 1'b0);
        run_all(8'h05, 8'h07, 1'b1);
        run_all(8'h80, 8'h01, 1'b1);
        run_all(8'hA5, 8'h5B, 1'b0);

        // start pulsed mid-RUN with different operands must be ignored (DIGIT=1)
        e1 = model(8'h12, 8'h34, 1'b0);
        a = 8'h12; b = 8'h34; sub = 1'b0; start_v[0] = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            start_v[0] = (cyc == 3);
            if (cyc == 3) begin a = 8'hAA; b = 8'h55; sub = 1'b1; end
        end while (!done_v[0] && cyc < 20);
        check("ignore latency", cyc - 1, 8);
        check("ignore sum", sum_v[0], e1[7:0]);
        check("ignore cout", cout_v[0], e1[9]);
        check("ignore ovf", ovf_v[0], e1[8]);
        @(negedge clk);

        // start held through DONE: back-to-back operation, done spaced N+1
        e1 = model(8'h3C, 8'hC5, 1'b0);
        e2 = model(8'h90, 8'h20, 1'b1);
        a = 8'h3C; b = 8'hC5; sub = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        cyc = 1;
        a = 8'h90; b = 8'h20; sub = 1'b1;
        while (!done_v[0] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b first latency", cyc - 1, 8);
        check("b2b first sum", sum_v[0], e1[7:0]);
        check("b2b first cout", cout_v[0], e1[9]);
        check("b2b first ovf", ovf_v[0], e1[8]);
        @(negedge clk);
        start_v[0] = 1'b0;
        gap = 1;
        unstable = 0;
        while (!done_v[0] && gap < 20) begin
            if (sum_v[0] !== e1[7:0]) unstable++;
            @(negedge clk);
            gap++;
        end
        check("b2b done spacing", gap, 9);
        check("b2b sum held", unstable, 0);
        check("b2b second sum", sum_v[0], e2[7:0]);
        check("b2b second cout", cout_v[0], e2[9]);
        check("b2b second ovf", ovf_v[0], e2[8]);
        @(negedge clk);

        // rst in RUN cycle 4 aborts the operation
        a = 8'h5A; b = 8'h33; sub = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-abort busy", busy_v[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ready", ready_v[0], 1);
        check("abort busy", busy_v[0], 0);
        check("abort done", done_v[0], 0);
        check("abort sum", sum_v[0], 0);
        check("abort cout", cout_v[0], 0);
        check("abort ovf", ovf_v[0], 0);
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0]) done_seen++;
        end
        check("abort no done", done_seen, 0);
        run_all(8'hC8, 8'h64, 1'b1);

        // Randomized sweep
        for (int i = 0; i < 1000; i++) begin
            run_all(8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor. It is the sequential successor to the single-bit full-adder cell. Two WIDTH-bit operands are captured on a start handshake and processed LSB-first, DIGIT bits per clock, through a registered carry. The block returns sum, carry-out and signed overflow with a one-cycle done pulse. It targets area-constrained datapaths where a full-width adder is not justified.

## Interface
- WIDTH, 8, operand/result width; WIDTH >= 2
- DIGIT, 1, bits processed per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0 (elaboration error otherwise)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  request; accepted when start && ready at a clk edge
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  block can accept start (IDLE or DONE state)
- busy  output  1  computation in progress (RUN state)
- done  output  1  one-cycle pulse: result registers just updated
- sum  output  WIDTH  result, mod 2^WIDTH
- cout  output  1  carry out of MSB (for sub: 1 = no borrow, i.e. a >= b unsigned)
- ovf  output  1  two's-complement overflow

## Operation
- N = WIDTH/DIGIT digit steps per operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready=1. start → RUN.
  - RUN: busy=1, ready=0. Stays for N cycles, then → DONE.
  - DONE: done=1, ready=1. start → RUN; otherwise → IDLE.
- On accept:
  - A shift register ← a.
  - B shift register ← (sub ? ~b : b).
  - carry ← sub.
  - digit counter ← 0.
  - Partial-sum shift register cleared.
- Each RUN cycle:
  - Add the low DIGIT bits of A, B and carry; shift the DIGIT result bits into the partial-sum register from the top.
  - Carry register ← digit carry-out.
  - A and B shift right by DIGIT.
  - Counter increments.
- On the final digit (counter == N−1):
  - sum ← completed partial sum.
  - cout ← final carry.
  - ovf ← carry into MSB XOR carry out of MSB.
  - State → DONE.
- Arithmetic contract: {cout, sum} = a + (sub ? ~b : b) + sub, computed at WIDTH+1 bits.
- sum/cout/ovf change only on the completion edge. They hold their value through IDLE and the next RUN until the next completion.
- start while busy is ignored: no queueing, no effect on the operation in flight.
- Operand inputs may change freely after the accepting edge.

## Timing
- Reset values: state IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, internal registers 0.
- rst asserted mid-RUN aborts the operation: state IDLE on the next edge, outputs at reset values, no done pulse. rst has priority over start.
- Latency: start accepted at edge E0 → busy=1 from E0 to E(N) → done=1 in the cycle after E(N). Result is valid on the same edge that done rises.
- Back-to-back: start held high in the DONE cycle is accepted at E(N+1). Throughput is one operation per N+1 cycles.
- done is never high for two consecutive cycles.
- ready and busy are mutually exclusive every cycle.

## Structure
- Package serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a localparam function for the counter width: $clog2(WIDTH/DIGIT), minimum 1.
- Sub-module digit_adder:
  - combinational, DIGIT-wide ripple of full-adder cells;
  - inputs x, y, cin; outputs s, cout, and c_msb_in (carry into its top bit, used for ovf on the final digit).
- Top level contains the FSM, counter, shift registers and result registers.

## Test plan
- WIDTH=8, DIGIT=1, a=8'h00, b=8'h00, sub=0 → sum=8'h00, cout=0, ovf=0; done exactly 8 cycles after the accept edge; busy high for 8 cycles.
- a=8'hFF, b=8'h01, add → sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1.
- Subtract:
  - a=8'h05, b=8'h07 → sum=8'hFE, cout=0, ovf=0.
  - a=8'h80, b=8'h01 → sum=8'h7F, cout=1, ovf=1.
- Handshake:
  - start pulsed mid-RUN with different operands → ignored; the original result is returned.
  - start held through DONE → second operation accepted, done pulses spaced 9 cycles apart.
  - sum is stable between the two done pulses.
- rst asserted at RUN cycle 4 → next cycle state IDLE, ready=1, busy=0, sum=0, no done pulse. A subsequent operation completes correctly.
- WIDTH=8, DIGIT=4, a=8'hA5, b=8'h5B, add → sum=8'h00, cout=1, ovf=0; done 2 cycles after accept. Also run a randomized sweep of 1000 operands against the WIDTH+1-bit reference equation for DIGIT ∈ {1, 2, 8}.
